// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one single-precision sqrt unit among NREQ requesters.
// Optional macro SQRT_BYPASS_EN: special-case operands are answered without the sqrt unit.
module sqrt_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [NREQ-1:0]      req_a_stb,
    output logic [NREQ-1:0]      req_a_ack,
    output logic [31:0]          resp_z,
    output logic [NREQ-1:0]      resp_z_stb,
    input  logic [NREQ-1:0]      resp_z_ack,
    output logic [31:0]          sqrt_a,
    output logic                 sqrt_a_stb,
    input  logic                 sqrt_a_ack,
    input  logic [31:0]          sqrt_z,
    input  logic                 sqrt_z_stb,
    output logic                 sqrt_z_ack,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic [1:0]           state_dbg
);

    // Handshakes: a transfer happens on the clock edge where stb and ack are both high;
    // the producer holds stb and data stable until that edge.
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    state_t            state, state_nxt;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    rr_nxt;
    logic [31:0]       op_reg;
    logic [31:0]       res_reg;
    logic [NREQ-1:0]   ack_q;
    logic              z_ack_q;
    logic              any_req;
    logic [IDW-1:0]    gnt_idx;
    logic [IDW:0]      cand;
    logic [31:0]       sel_op;
    logic              byp;
    logic [31:0]       byp_val;

    // Scan downward so the smallest offset from rr_ptr overwrites earlier matches.
    always_comb begin
        any_req = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            if (req_a_stb[cand[IDW-1:0]]) begin
                any_req = 1'b1;
                gnt_idx = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i))
                sel_op = req_a[32*i +: 32];
        end
    end

    assign rr_nxt = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef SQRT_BYPASS_EN
    always_comb begin
        byp     = 1'b0;
        byp_val = 32'h7FC0_0000;
        if (sel_op[30:23] == 8'hFF) begin
            byp     = 1'b1;
            byp_val = (sel_op[22:0] == 23'd0 && !sel_op[31]) ? 32'h7F80_0000 : 32'h7FC0_0000;
        end else if (sel_op[30:0] == 31'd0) begin
            byp     = 1'b1;
            byp_val = sel_op;
        end else if (sel_op[31]) begin
            byp     = 1'b1;
            byp_val = 32'h7FC0_0000;
        end
    end
`else
    assign byp     = 1'b0;
    assign byp_val = 32'h0000_0000;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (any_req) state_nxt = byp ? RESP : ISSUE;
            ISSUE: if (sqrt_a_ack) state_nxt = WAIT;
            WAIT:  if (z_ack_q && !sqrt_z_stb) state_nxt = RESP;
            RESP:  if (resp_z_ack[grant_id]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr   <= '0;
            op_reg   <= '0;
            res_reg  <= '0;
            grant_id <= '0;
            ack_q    <= '0;
            z_ack_q  <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        op_reg   <= sel_op;
                        grant_id <= gnt_idx;
                        rr_ptr   <= rr_nxt;
                        ack_q    <= NREQ'(1) << gnt_idx;
                        if (byp)
                            res_reg <= byp_val;
                    end
                end
                WAIT: begin
                    // Capture on the first strobe cycle, then hold ack until the unit drops its strobe.
                    if (sqrt_z_stb && !z_ack_q) begin
                        res_reg <= sqrt_z;
                        z_ack_q <= 1'b1;
                    end else if (z_ack_q && !sqrt_z_stb) begin
                        z_ack_q <= 1'b0;
                    end
                end
                default: z_ack_q <= 1'b0;
            endcase
        end
    end

    always_comb begin
        sqrt_a     = (state == ISSUE) ? op_reg : 32'd0;
        sqrt_a_stb = (state == ISSUE);
        resp_z     = (state == RESP) ? res_reg : 32'd0;
        resp_z_stb = (state == RESP) ? (NREQ'(1) << grant_id) : '0;
        busy       = (state != IDLE);
        sqrt_z_ack = z_ack_q;
        req_a_ack  = ack_q;
        state_dbg  = state;
    end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter with a behavioural sqrt unit answering from a lookup table.
module tb_sqrt_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [32*NREQ-1:0]  req_a = '0;
    logic [NREQ-1:0]     req_a_stb = '0;
    logic [NREQ-1:0]     req_a_ack;
    logic [31:0]         resp_z;
    logic [NREQ-1:0]     resp_z_stb;
    logic [NREQ-1:0]     resp_z_ack = '0;
    logic [31:0]         sqrt_a;
    logic                sqrt_a_stb;
    logic                sqrt_a_ack;
    logic [31:0]         sqrt_z;
    logic                sqrt_z_stb;
    logic                sqrt_z_ack;
    logic                busy;
    logic [IDW-1:0]      grant_id;
    logic [1:0]          state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    bit auto_clear  = 1'b1;
    bit model_stall = 1'b0;
    int issue_cnt   = 0;

    sqrt_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_a_stb(req_a_stb), .req_a_ack(req_a_ack),
        .resp_z(resp_z), .resp_z_stb(resp_z_stb), .resp_z_ack(resp_z_ack),
        .sqrt_a(sqrt_a), .sqrt_a_stb(sqrt_a_stb), .sqrt_a_ack(sqrt_a_ack),
        .sqrt_z(sqrt_z), .sqrt_z_stb(sqrt_z_stb), .sqrt_z_ack(sqrt_z_ack),
        .busy(busy), .grant_id(grant_id), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic apply_reset;
        rst = 1'b0;
        req_a_stb = '0;
        resp_z_ack = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- sqrt unit model ----------------
    function automatic logic [31:0] sqrt_lut(input logic [31:0] a);
        case (a)
            32'h3F80_0000: sqrt_lut = 32'h3F80_0000;
            32'h4080_0000: sqrt_lut = 32'h4000_0000;
            32'h4110_0000: sqrt_lut = 32'h4040_0000;
            32'h4180_0000: sqrt_lut = 32'h4080_0000;
            32'h41C8_0000: sqrt_lut = 32'h40A0_0000;
            32'h4210_0000: sqrt_lut = 32'h40C0_0000;
            32'h4244_0000: sqrt_lut = 32'h40E0_0000;
            32'hC080_0000: sqrt_lut = 32'h7FC0_0000;
            default:       sqrt_lut = 32'hDEAD_BEEF;
        endcase
    endfunction

    initial begin
        int mstate;
        int mcnt;
        logic [31:0] mop;
        mstate = 0; mcnt = 0; mop = '0;
        sqrt_a_ack = 1'b0; sqrt_z_stb = 1'b0; sqrt_z = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                sqrt_a_ack = 1'b0; sqrt_z_stb = 1'b0; sqrt_z = '0; mstate = 0;
            end else begin
                case (mstate)
                    0: if (sqrt_a_stb) begin
                        sqrt_a_ack = 1'b1; mop = sqrt_a; mstate = 1; issue_cnt++;
                    end
                    1: begin sqrt_a_ack = 1'b0; mcnt = 3; mstate = 2; end
                    2: if (mcnt == 0) begin
                        sqrt_z = sqrt_lut(mop); sqrt_z_stb = 1'b1; mstate = 3;
                    end else mcnt--;
                    3: if (sqrt_z_ack && !model_stall) begin
                        sqrt_z_stb = 1'b0; sqrt_z = '0; mstate = 0;
                    end
                    default: mstate = 0;
                endcase
            end
        end
    end

    // ---------------- requester drivers ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (auto_clear)
                for (int i = 0; i < NREQ; i++)
                    if (req_a_ack[i]) req_a_stb[i] = 1'b0;
        end
    end

    task automatic set_op(input int i, input logic [31:0] v);
        req_a[32*i +: 32] = v;
    endtask

    task automatic serve_resp(output logic [31:0] z, output logic [NREQ-1:0] stb,
                              output logic [IDW-1:0] gid, output bit ok);
        ok = 1'b0; z = '0; stb = '0; gid = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (resp_z_stb != '0) begin ok = 1'b1; break; end
        end
        if (ok) begin
            z = resp_z; stb = resp_z_stb; gid = grant_id;
            resp_z_ack = resp_z_stb;
            @(negedge clk);
            resp_z_ack = '0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        @(negedge clk);
        n_checks++; if (req_a_ack !== 4'b0) $display("FAIL reset_req_a_ack: got %b want 0", req_a_ack); else n_pass++;
        n_checks++; if (resp_z !== 32'd0) $display("FAIL reset_resp_z: got %h want 0", resp_z); else n_pass++;
        n_checks++; if (resp_z_stb !== 4'b0) $display("FAIL reset_resp_z_stb: got %b want 0", resp_z_stb); else n_pass++;
        n_checks++; if (sqrt_a !== 32'd0) $display("FAIL reset_sqrt_a: got %h want 0", sqrt_a); else n_pass++;
        n_checks++; if (sqrt_a_stb !== 1'b0) $display("FAIL reset_sqrt_a_stb: got %b want 0", sqrt_a_stb); else n_pass++;
        n_checks++; if (sqrt_z_ack !== 1'b0) $display("FAIL reset_sqrt_z_ack: got %b want 0", sqrt_z_ack); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d want 0", grant_id); else n_pass++;
        n_checks++; if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d want 0", state_dbg); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        bit busy_bad;
        bit seen;
        set_op(0, 32'h4080_0000);
        req_a_stb[0] = 1'b1;
        @(negedge clk);
        n_checks++; if (req_a_ack !== 4'b0001) $display("FAIL single_ack: got %b want 0001", req_a_ack); else n_pass++;
        n_checks++; if (sqrt_a_stb !== 1'b1) $display("FAIL single_sqrt_a_stb: got %b want 1", sqrt_a_stb); else n_pass++;
        n_checks++; if (sqrt_a !== 32'h4080_0000) $display("FAIL single_sqrt_a: got %h want 40800000", sqrt_a); else n_pass++;
        n_checks++; if (grant_id !== 2'd0) $display("FAIL single_grant: got %0d want 0", grant_id); else n_pass++;
        @(negedge clk);
        n_checks++; if (req_a_ack !== 4'b0) $display("FAIL single_ack_pulse: got %b want 0", req_a_ack); else n_pass++;
        busy_bad = 1'b0; seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (resp_z_stb != '0) begin seen = 1'b1; break; end
            if (busy !== 1'b1) busy_bad = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen !== 1'b1) $display("FAIL single_resp_seen: got %b want 1", seen); else n_pass++;
        n_checks++; if (resp_z !== 32'h4000_0000) $display("FAIL single_resp_z: got %h want 40000000", resp_z); else n_pass++;
        n_checks++; if (resp_z_stb !== 4'b0001) $display("FAIL single_resp_stb: got %b want 0001", resp_z_stb); else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++; if (busy_bad !== 1'b0 || busy !== 1'b1) $display("FAIL single_busy_hold: got bad=%b busy=%b want bad=0 busy=1", busy_bad, busy); else n_pass++;
        resp_z_ack[0] = 1'b1;
        @(negedge clk);
        resp_z_ack = '0;
        n_checks++; if (resp_z_stb !== 4'b0) $display("FAIL single_resp_clear: got %b want 0", resp_z_stb); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_simultaneous;
        logic [31:0] z; logic [NREQ-1:0] stb; logic [IDW-1:0] gid; bit ok;
        apply_reset();
        set_op(1, 32'h4180_0000);
        set_op(3, 32'h4110_0000);
        req_a_stb = 4'b1010;
        serve_resp(z, stb, gid, ok);
        n_checks++; if (!ok || gid !== 2'd1) $display("FAIL simul_first_grant: got %0d ok=%b want 1", gid, ok); else n_pass++;
        n_checks++; if (z !== 32'h4080_0000 || stb !== 4'b0010) $display("FAIL simul_first_z: got %h/%b want 40800000/0010", z, stb); else n_pass++;
        serve_resp(z, stb, gid, ok);
        n_checks++; if (!ok || gid !== 2'd3) $display("FAIL simul_second_grant: got %0d ok=%b want 3", gid, ok); else n_pass++;
        n_checks++; if (z !== 32'h4040_0000 || stb !== 4'b1000) $display("FAIL simul_second_z: got %h/%b want 40400000/1000", z, stb); else n_pass++;
    endtask

    task automatic test_round_robin;
        logic [31:0] z; logic [NREQ-1:0] stb; logic [IDW-1:0] gid; bit ok;
        logic [31:0] exp_z [NREQ];
        exp_z[0] = 32'h3F80_0000; exp_z[1] = 32'h4000_0000;
        exp_z[2] = 32'h4040_0000; exp_z[3] = 32'h4080_0000;
        set_op(0, 32'h3F80_0000); set_op(1, 32'h4080_0000);
        set_op(2, 32'h4110_0000); set_op(3, 32'h4180_0000);
        auto_clear = 1'b0;
        req_a_stb = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (req_a_ack != '0) break;
                end
                req_a_stb = '0;
            end
            serve_resp(z, stb, gid, ok);
            n_checks++; if (!ok || gid !== IDW'(k % 4)) $display("FAIL rr_grant_%0d: got %0d ok=%b want %0d", k, gid, ok, k % 4); else n_pass++;
            n_checks++; if (z !== exp_z[k % 4]) $display("FAIL rr_z_%0d: got %h want %h", k, z, exp_z[k % 4]); else n_pass++;
        end
        auto_clear = 1'b1;
    endtask

    task automatic test_backpressure;
        logic [31:0] z; logic [NREQ-1:0] stb; logic [IDW-1:0] gid; bit ok;
        bit seen, bad_stb, bad_z, bad_issue, bad_grant;
        set_op(2, 32'h41C8_0000);
        req_a_stb[2] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (resp_z_stb != '0) begin seen = 1'b1; break; end
        end
        n_checks++; if (seen !== 1'b1) $display("FAIL bp_resp_seen: got %b want 1", seen); else n_pass++;
        set_op(0, 32'h4210_0000);
        req_a_stb[0] = 1'b1;
        resp_z_ack = 4'b0010;
        bad_stb = 0; bad_z = 0; bad_issue = 0; bad_grant = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (resp_z_stb !== 4'b0100) bad_stb = 1'b1;
            if (resp_z !== 32'h40A0_0000) bad_z = 1'b1;
            if (sqrt_a_stb !== 1'b0) bad_issue = 1'b1;
            if (req_a_ack !== 4'b0) bad_grant = 1'b1;
        end
        n_checks++; if (bad_stb) $display("FAIL bp_stb_stable: got unstable want 0100 held"); else n_pass++;
        n_checks++; if (bad_z) $display("FAIL bp_z_stable: got unstable want 40a00000 held"); else n_pass++;
        n_checks++; if (bad_issue) $display("FAIL bp_no_issue: got sqrt_a_stb=1 want 0"); else n_pass++;
        n_checks++; if (bad_grant) $display("FAIL bp_no_grant: got early req_a_ack want none"); else n_pass++;
        resp_z_ack = 4'b0100;
        @(negedge clk);
        resp_z_ack = '0;
        serve_resp(z, stb, gid, ok);
        n_checks++; if (!ok || gid !== 2'd0) $display("FAIL bp_next_grant: got %0d ok=%b want 0", gid, ok); else n_pass++;
        n_checks++; if (z !== 32'h40C0_0000) $display("FAIL bp_next_z: got %h want 40c00000", z); else n_pass++;
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] z; logic [NREQ-1:0] stb; logic [IDW-1:0] gid; bit ok;
        bit reached;
        model_stall = 1'b1;
        set_op(1, 32'h4244_0000);
        req_a_stb[1] = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (sqrt_z_ack === 1'b1) begin reached = 1'b1; break; end
        end
        n_checks++; if (reached !== 1'b1 || state_dbg !== 2'd2) $display("FAIL rst_wait_reached: got %b state=%0d want 1 state=2", reached, state_dbg); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (sqrt_z_ack !== 1'b0) $display("FAIL rst_sqrt_z_ack: got %b want 0", sqrt_z_ack); else n_pass++;
        n_checks++; if (busy !== 1'b0 || state_dbg !== 2'd0) $display("FAIL rst_state: got busy=%b state=%0d want 0/0", busy, state_dbg); else n_pass++;
        n_checks++; if (grant_id !== 2'd0) $display("FAIL rst_grant_id: got %0d want 0", grant_id); else n_pass++;
        n_checks++; if (sqrt_a_stb !== 1'b0 || resp_z_stb !== 4'b0 || req_a_ack !== 4'b0) $display("FAIL rst_strobes: got %b/%b/%b want 0/0/0", sqrt_a_stb, resp_z_stb, req_a_ack); else n_pass++;
        repeat (2) @(negedge clk);
        model_stall = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        set_op(1, 32'h4244_0000);
        set_op(3, 32'h3F80_0000);
        req_a_stb = 4'b1010;
        serve_resp(z, stb, gid, ok);
        n_checks++; if (!ok || gid !== 2'd1 || z !== 32'h40E0_0000) $display("FAIL rst_after_first: got id=%0d z=%h ok=%b want 1/40e00000", gid, z, ok); else n_pass++;
        serve_resp(z, stb, gid, ok);
        n_checks++; if (!ok || gid !== 2'd3 || z !== 32'h3F80_0000) $display("FAIL rst_after_second: got id=%0d z=%h ok=%b want 3/3f800000", gid, z, ok); else n_pass++;
    endtask

`ifdef SQRT_BYPASS_EN
    task automatic test_bypass;
        int issue0;
        logic [31:0] ops [3];
        logic [31:0] exps [3];
        ops[0] = 32'hC080_0000; exps[0] = 32'h7FC0_0000;
        ops[1] = 32'h8000_0000; exps[1] = 32'h8000_0000;
        ops[2] = 32'h7F80_0000; exps[2] = 32'h7F80_0000;
        issue0 = issue_cnt;
        for (int k = 0; k < 3; k++) begin
            set_op(0, ops[k]);
            req_a_stb[0] = 1'b1;
            @(negedge clk);
            n_checks++; if (req_a_ack !== 4'b0001 || resp_z_stb !== 4'b0001) $display("FAIL byp_resp_%0d: got ack=%b stb=%b want 0001/0001", k, req_a_ack, resp_z_stb); else n_pass++;
            n_checks++; if (resp_z !== exps[k]) $display("FAIL byp_z_%0d: got %h want %h", k, resp_z, exps[k]); else n_pass++;
            resp_z_ack = 4'b0001;
            @(negedge clk);
            resp_z_ack = '0;
        end
        n_checks++; if (issue_cnt !== issue0) $display("FAIL byp_no_issue: got %0d issues want 0", issue_cnt - issue0); else n_pass++;
    endtask
`else
    task automatic test_bypass;
        logic [31:0] z; logic [NREQ-1:0] stb; logic [IDW-1:0] gid; bit ok;
        int issue0;
        issue0 = issue_cnt;
        set_op(0, 32'hC080_0000);
        req_a_stb[0] = 1'b1;
        serve_resp(z, stb, gid, ok);
        n_checks++; if (!ok || z !== 32'h7FC0_0000) $display("FAIL neg_z: got %h ok=%b want 7fc00000", z, ok); else n_pass++;
        n_checks++; if (issue_cnt !== issue0 + 1) $display("FAIL neg_issued: got %0d issues want 1", issue_cnt - issue0); else n_pass++;
    endtask
`endif

    // ---------------- sequence / report ----------------
    initial begin
        rst = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_round_robin();
        test_backpressure();
        test_reset_mid_wait();
        test_bypass();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
